// File: rtl/sg_list_writer_32_if.sv
// Element handshake and SG buffer FIFO write port for sg_list_writer_32.
// slave is the writer's side, master is the element source / FIFO side.
interface sg_list_writer_32_if #(
  parameter int DATA_W = 32
) ();
  logic              VALID;
  logic              RDY;
  logic [63:0]       ADDR;
  logic [31:0]       LEN;
  logic [DATA_W-1:0] BUF_DATA;
  logic              BUF_DATA_WEN;
  logic              BUF_DATA_FULL;

  modport slave (
    input  VALID, ADDR, LEN, BUF_DATA_FULL,
    output RDY, BUF_DATA, BUF_DATA_WEN
  );

  modport master (
    output VALID, ADDR, LEN, BUF_DATA_FULL,
    input  RDY, BUF_DATA, BUF_DATA_WEN
  );
endinterface

// File: rtl/sg_list_writer_32.sv
// Packs one SG element (64-bit address, 32-bit length) into a four-word FIFO
// record: addr[31:0], addr[63:32], len, pad. Stalls on FIFO full.
//
// state | meaning
// IDLE  | waiting for an element, RDY=1
// WR_0  | writing addr[31:0]
// WR_1  | writing addr[63:32]
// WR_2  | writing len
// WR_3  | writing pad word; may accept the next element back-to-back
module sg_list_writer_32 #(
  parameter logic [8:0]  C_DATA_WIDTH  = 9'd32,
  parameter logic [31:0] C_PAD_WORD    = 32'd0,
  parameter int          C_COUNT_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  sg_list_writer_32_if.slave       bus,
  output logic                     BUSY,
  output logic [C_COUNT_WIDTH-1:0] COUNT
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR_0 = 3'd1,
    S_WR_1 = 3'd2,
    S_WR_2 = 3'd3,
    S_WR_3 = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [63:0]              addr_q, addr_d;
  logic [31:0]              len_q, len_d;
  logic [C_COUNT_WIDTH-1:0] count_q, count_d;
  logic                     rdy;
  logic                     wen;
  logic [C_DATA_WIDTH-1:0]  data;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    count_d = count_q;
    rdy     = 1'b0;
    wen     = 1'b0;
    data    = '0;

    case (state_q)
      S_IDLE: begin
        rdy = 1'b1;
        if (bus.VALID) state_d = S_WR_0;
      end
      S_WR_0: begin
        data = addr_q[31:0];
        wen  = !bus.BUF_DATA_FULL;
        if (wen) state_d = S_WR_1;
      end
      S_WR_1: begin
        data = addr_q[63:32];
        wen  = !bus.BUF_DATA_FULL;
        if (wen) state_d = S_WR_2;
      end
      S_WR_2: begin
        data = len_q;
        wen  = !bus.BUF_DATA_FULL;
        if (wen) state_d = S_WR_3;
      end
      S_WR_3: begin
        data = C_PAD_WORD;
        wen  = !bus.BUF_DATA_FULL;
        rdy  = !bus.BUF_DATA_FULL;
        if (wen) begin
          count_d = count_q + 1'b1;
          state_d = bus.VALID ? S_WR_0 : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Capture is shared by IDLE and the back-to-back path out of WR_3.
    if (rdy && bus.VALID) begin
      addr_d = bus.ADDR;
      len_d  = bus.LEN;
    end
  end

  assign bus.RDY          = rdy;
  assign bus.BUF_DATA_WEN = wen;
  assign bus.BUF_DATA     = data;
  assign BUSY             = (state_q != S_IDLE);
  assign COUNT            = count_q;

endmodule

// File: tb/tb_sg_list_writer_32.sv
// Directed bench for sg_list_writer_32 with a 2-bit record counter so the
// wrap is reached quickly.
module tb_sg_list_writer_32;

  logic       CLK;
  logic       RST_N;
  logic       BUSY;
  logic [1:0] COUNT;

  sg_list_writer_32_if #(.DATA_W(32)) bus ();

  sg_list_writer_32 #(
    .C_DATA_WIDTH (9'd32),
    .C_PAD_WORD   (32'd0),
    .C_COUNT_WIDTH(2)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus.slave),
    .BUSY (BUSY),
    .COUNT(COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          n_vec = 0;
  int          n_err = 0;
  int          cnt_e = 0;
  logic [31:0] wq[$];

  always @(posedge CLK) if (RST_N && bus.BUF_DATA_WEN) wq.push_back(bus.BUF_DATA);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_cycle(input string tag, input logic wen_e, input logic [31:0] data_e,
                           input logic rdy_e, input logic busy_e);
    check({tag, "_wen"},  bus.BUF_DATA_WEN, wen_e);
    check({tag, "_data"}, bus.BUF_DATA, data_e);
    check({tag, "_rdy"},  bus.RDY, rdy_e);
    check({tag, "_busy"}, BUSY, busy_e);
  endtask

  task automatic run_record(input string tag, input logic [63:0] a, input logic [31:0] l);
    logic [31:0] w [4];
    w[0] = a[31:0]; w[1] = a[63:32]; w[2] = l; w[3] = 32'd0;
    bus.VALID = 1'b1; bus.ADDR = a; bus.LEN = l;
    #1;
    check({tag, "_idle_rdy"}, bus.RDY, 1'b1);
    tick();
    bus.VALID = 1'b0; bus.ADDR = ~a; bus.LEN = ~l;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_cycle($sformatf("%s_w%0d", tag, i), 1'b1, w[i], (i == 3), 1'b1);
      if (i == 3) check({tag, "_cnt_before"}, COUNT, cnt_e[1:0]);
      tick();
    end
    cnt_e = (cnt_e + 1) % 4;
    check({tag, "_count"}, COUNT, cnt_e[1:0]);
    check({tag, "_idle_busy"}, BUSY, 1'b0);
    check({tag, "_idle_wen"}, bus.BUF_DATA_WEN, 1'b0);
  endtask

  initial begin
    logic [63:0] a2 [3];
    logic [31:0] l2 [3];
    logic [63:0] a;
    logic [63:0] b;
    logic [31:0] w [4];

    RST_N = 1'b0;
    bus.VALID = 1'b0; bus.ADDR = '0; bus.LEN = '0; bus.BUF_DATA_FULL = 1'b0;
    repeat (3) tick();
    chk_cycle("reset", 1'b0, 32'd0, 1'b1, 1'b0);
    check("reset_count", COUNT, 2'd0);
    #3 RST_N = 1'b1;
    tick();

    // single element
    run_record("single", 64'h0000_0001_8000_1000, 32'd1024);

    // three back-to-back elements with VALID held high
    a2[0] = 64'h1111_2222_3333_4444; l2[0] = 32'd16;
    a2[1] = 64'h5555_6666_7777_8888; l2[1] = 32'd17;
    a2[2] = 64'h9999_AAAA_BBBB_CCCC; l2[2] = 32'd18;
    wq.delete();
    bus.VALID = 1'b1; bus.ADDR = a2[0]; bus.LEN = l2[0];
    #1;
    check("b2b_idle_rdy", bus.RDY, 1'b1);
    tick();
    for (int e = 0; e < 3; e++) begin
      w[0] = a2[e][31:0]; w[1] = a2[e][63:32]; w[2] = l2[e]; w[3] = 32'd0;
      for (int i = 0; i < 4; i++) begin
        if (i == 3) begin
          if (e < 2) begin bus.ADDR = a2[e+1]; bus.LEN = l2[e+1]; end
          else bus.VALID = 1'b0;
        end else begin
          bus.ADDR = 64'hFFFF_0000_FFFF_0000; bus.LEN = 32'hFFFF_FFFF;
        end
        #1;
        chk_cycle($sformatf("b2b_e%0d_w%0d", e, i), 1'b1, w[i], (i == 3), 1'b1);
        tick();
      end
      cnt_e = (cnt_e + 1) % 4;
    end
    check("b2b_count", COUNT, cnt_e[1:0]);
    check("b2b_nwrites", wq.size(), 12);
    check("b2b_idle", BUSY, 1'b0);

    // FULL held for 3 cycles in WR_1
    a = 64'h0000_0001_2222_3333;
    wq.delete();
    bus.VALID = 1'b1; bus.ADDR = a; bus.LEN = 32'd7;
    tick();
    bus.VALID = 1'b0;
    #1; chk_cycle("full_w0", 1'b1, 32'h2222_3333, 1'b0, 1'b1);
    tick();
    bus.BUF_DATA_FULL = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1; chk_cycle($sformatf("full_stall%0d", k), 1'b0, 32'h0000_0001, 1'b0, 1'b1);
      tick();
    end
    bus.BUF_DATA_FULL = 1'b0;
    #1; chk_cycle("full_w1", 1'b1, 32'h0000_0001, 1'b0, 1'b1);
    tick();
    #1; chk_cycle("full_w2", 1'b1, 32'd7, 1'b0, 1'b1);
    tick();
    #1; chk_cycle("full_w3", 1'b1, 32'd0, 1'b1, 1'b1);
    tick();
    cnt_e = (cnt_e + 1) % 4;
    check("full_count", COUNT, cnt_e[1:0]);
    check("full_nwrites", wq.size(), 4);
    if (wq.size() == 4) begin
      check("full_q0", wq[0], 32'h2222_3333);
      check("full_q1", wq[1], 32'h0000_0001);
      check("full_q2", wq[2], 32'd7);
      check("full_q3", wq[3], 32'd0);
    end

    // FULL in WR_3 with VALID high blocks the handshake
    a = 64'hAAAA_0000_BBBB_0001;
    b = 64'hCCCC_0002_DDDD_0003;
    bus.VALID = 1'b1; bus.ADDR = a; bus.LEN = 32'd9;
    tick();
    bus.VALID = 1'b0;
    repeat (3) tick();
    bus.VALID = 1'b1; bus.ADDR = b; bus.LEN = 32'd33; bus.BUF_DATA_FULL = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1; chk_cycle($sformatf("w3full_stall%0d", k), 1'b0, 32'd0, 1'b0, 1'b1);
      check("w3full_count_hold", COUNT, cnt_e[1:0]);
      tick();
    end
    bus.BUF_DATA_FULL = 1'b0;
    #1; chk_cycle("w3full_release", 1'b1, 32'd0, 1'b1, 1'b1);
    tick();
    cnt_e = (cnt_e + 1) % 4;
    bus.VALID = 1'b0; bus.ADDR = '0; bus.LEN = '0;
    #1; chk_cycle("w3full_next_w0", 1'b1, 32'hDDDD_0003, 1'b0, 1'b1);
    check("w3full_count", COUNT, cnt_e[1:0]);
    tick();
    #1; chk_cycle("w3full_next_w1", 1'b1, 32'hCCCC_0002, 1'b0, 1'b1);
    tick();
    #1; chk_cycle("w3full_next_w2", 1'b1, 32'd33, 1'b0, 1'b1);
    tick();
    tick();
    cnt_e = (cnt_e + 1) % 4;
    check("w3full_count2", COUNT, cnt_e[1:0]);

    // async reset in WR_2
    bus.VALID = 1'b1; bus.ADDR = 64'h0123_4567_89AB_CDEF; bus.LEN = 32'd5;
    tick();
    bus.VALID = 1'b0;
    tick(); tick();
    #1; chk_cycle("rst_pre_w2", 1'b1, 32'd5, 1'b0, 1'b1);
    #1 RST_N = 1'b0;
    #1;
    chk_cycle("rst_mid", 1'b0, 32'd0, 1'b1, 1'b0);
    check("rst_mid_count", COUNT, 2'd0);
    cnt_e = 0;
    #2 RST_N = 1'b1;
    tick();

    // restart with LEN=0, then run the counter through its wrap
    run_record("len0", 64'h0000_0002_0000_0040, 32'd0);
    run_record("wrap_a", 64'h0000_0003_0000_0080, 32'd1);
    run_record("wrap_b", 64'h0000_0004_0000_00C0, 32'd2);
    run_record("wrap_c", 64'h0000_0005_0000_0100, 32'd3);
    run_record("wrap_d", 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
